// File: rtl/sdram_arbiter.sv
// Single-port SDRAM/dpram scheduler: loader bypass while in reset, otherwise
// video-priority arbitration between video fetch and CPU with starvation bound.
module sdram_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int RD_LAT       = 1,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              F14Mx2,
  input  logic              CPU_RESET,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              er_busy,
  input  logic              er_wr,
  input  logic [ADDR_W-1:0] er_addr,
  input  logic [7:0]        er_data,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_wr,
  input  logic [7:0]        mem_dout,
  output logic [1:0]        grant
);

  // state | meaning
  // IDLE  | arbitrate sampled requests
  // ACC   | one-cycle memory access, mem_wr follows latched we
  // WAIT  | read latency countdown, capture mem_dout when count is 1
  // ACK   | one-cycle completion pulse to the owner
  typedef enum logic [1:0] {IDLE, ACC, WAIT, ACK} state_t;

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);
  localparam logic [2:0] LAT      = 3'(RD_LAT);

  state_t            state, state_nx;
  logic              own_cpu, own_cpu_nx;
  logic [ADDR_W-1:0] addr_r, addr_nx;
  logic              we_r, we_nx;
  logic [7:0]        din_r, din_nx;
  logic [2:0]        lat_cnt, lat_nx;
  logic [3:0]        starve, starve_nx;
  logic [7:0]        rdata_r, rdata_nx;
  logic              take_cpu, take_vid;

  always_ff @(posedge F14Mx2 or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      state   <= IDLE;
      own_cpu <= 1'b0;
      addr_r  <= '0;
      we_r    <= 1'b0;
      din_r   <= '0;
      lat_cnt <= '0;
      starve  <= '0;
      rdata_r <= '0;
    end else begin
      state   <= state_nx;
      own_cpu <= own_cpu_nx;
      addr_r  <= addr_nx;
      we_r    <= we_nx;
      din_r   <= din_nx;
      lat_cnt <= lat_nx;
      starve  <= starve_nx;
      rdata_r <= rdata_nx;
    end
  end

  // A starved CPU overrides video; otherwise video wins any tie.
  assign take_cpu = cpu_req && ((starve == MAX_WAIT) || !vid_req);
  assign take_vid = vid_req && !take_cpu;

  always_comb begin
    state_nx   = state;
    own_cpu_nx = own_cpu;
    addr_nx    = addr_r;
    we_nx      = we_r;
    din_nx     = din_r;
    lat_nx     = lat_cnt;
    starve_nx  = starve;
    rdata_nx   = rdata_r;
    case (state)
      IDLE: begin
        if (take_cpu) begin
          own_cpu_nx = 1'b1;
          addr_nx    = cpu_addr;
          we_nx      = cpu_we;
          din_nx     = cpu_wdata;
          starve_nx  = '0;
          state_nx   = ACC;
        end else if (take_vid) begin
          own_cpu_nx = 1'b0;
          addr_nx    = vid_addr;
          we_nx      = 1'b0;
          state_nx   = ACC;
          if (!cpu_req)
            starve_nx = '0;
          else if (starve < MAX_WAIT)
            starve_nx = starve + 4'd1;
        end else begin
          starve_nx = '0;
        end
      end
      ACC: begin
        if (we_r) begin
          state_nx = ACK;
        end else begin
          lat_nx   = LAT;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        lat_nx = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          rdata_nx = mem_dout;
          state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bypass overrides the registered port combinationally so reset aborts at once.
  always_comb begin
    mem_addr = addr_r;
    mem_din  = din_r;
    mem_wr   = (state == ACC) && we_r;
    grant    = (state == IDLE) ? 2'd0 : (own_cpu ? 2'd2 : 2'd1);
    vid_ack  = (state == ACK) && !own_cpu;
    cpu_ack  = (state == ACK) && own_cpu;
    if (CPU_RESET) begin
      grant   = 2'd3;
      vid_ack = 1'b0;
      cpu_ack = 1'b0;
      if (dl_wr) begin
        mem_addr = dl_addr;
        mem_din  = dl_data;
        mem_wr   = 1'b1;
      end else begin
        mem_addr = er_addr;
        mem_din  = er_data;
        mem_wr   = er_busy && er_wr;
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: bypass vector table, transaction table,
// and hand-written priority, starvation, long-latency and abort sequences.
module tb_sdram_arbiter;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dl_wr = 1'b0;
  logic [AW-1:0] dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          er_busy = 1'b0;
  logic          er_wr = 1'b0;
  logic [AW-1:0] er_addr = '0;
  logic [7:0]    er_data = '0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          vid_ack, cpu_ack, mem_wr;
  logic [7:0]    rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant;

  logic          vid_req3 = 1'b0;
  logic          cpu_req3 = 1'b0;
  logic          vid_ack3, cpu_ack3, mem_wr3;
  logic [7:0]    rdata3, mem_din3;
  logic [AW-1:0] mem_addr3;
  logic [1:0]    grant3;
  logic [7:0]    cyc8 = '0;

  int n_checks = 0;
  int n_fail = 0;

  sdram_arbiter #(.ADDR_W(AW), .RD_LAT(1), .CPU_MAX_WAIT(4)) u_dut (
    .F14Mx2(clk), .CPU_RESET(rst),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .er_busy(er_busy), .er_wr(er_wr), .er_addr(er_addr), .er_data(er_data),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .grant(grant)
  );

  sdram_arbiter #(.ADDR_W(AW), .RD_LAT(3), .CPU_MAX_WAIT(4)) u_dut3 (
    .F14Mx2(clk), .CPU_RESET(rst),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .er_busy(er_busy), .er_wr(er_wr), .er_addr(er_addr), .er_data(er_data),
    .vid_req(vid_req3), .vid_addr(vid_addr), .vid_ack(vid_ack3),
    .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack3), .rdata(rdata3),
    .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_wr(mem_wr3), .mem_dout(cyc8),
    .grant(grant3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc8 <= cyc8 + 8'd1;

  // Model memory: 256 bytes on the low address byte, preset to addr ^ 0x3C.
  logic [7:0] mm [256];
  bit mm_init = 1'b0;
  always @(posedge clk) begin
    if (!mm_init) begin
      for (int i = 0; i < 256; i++) mm[i] = 8'(i) ^ 8'h3C;
      mm_init = 1'b1;
    end else if (mem_wr) begin
      mm[mem_addr[7:0]] = mem_din;
    end
  end
  assign mem_dout = mm[mem_addr[7:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (vid_ack || cpu_ack) check("ack_overlap", 32'(vid_ack & cpu_ack), 32'd0);

  typedef struct {
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          er_busy;
    logic          er_wr;
    logic [AW-1:0] er_addr;
    logic [7:0]    er_data;
    logic          reqs;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_din;
  } byp_t;

  typedef struct {
    logic          is_vid;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    int            exp_lat;
    logic [7:0]    exp_rd;
  } xf_t;

  task automatic xfer(input xf_t t, input string nm);
    int k;
    int nwr;
    @(posedge clk); #1;
    if (t.is_vid) begin
      vid_req = 1'b1; vid_addr = t.addr;
    end else begin
      cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
    end
    nwr = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_wr) begin
        nwr++;
        check({nm, "_wr_addr"}, 32'(mem_addr), 32'(t.addr));
        check({nm, "_wr_din"}, 32'(mem_din), 32'(t.wdata));
      end
      if (t.is_vid ? vid_ack : cpu_ack) break;
    end
    check({nm, "_ack_cycle"}, 32'(k), 32'(t.exp_lat));
    check({nm, "_wr_cycles"}, 32'(nwr), 32'(t.we));
    if (!t.we) check({nm, "_rdata"}, 32'(rdata), 32'(t.exp_rd));
    @(posedge clk); #1;
    vid_req = 1'b0;
    cpu_req = 1'b0;
  endtask

  byp_t bv[5];
  xf_t  xv[6];
  int   kv, kc, n, kk;
  int   seq[6];
  int   exp_seq[6];
  logic [7:0] c0;

  initial begin
    bv[0] = '{1'b1, 25'h10,      8'hA5, 1'b1, 1'b1, 25'h200, 8'h11, 1'b0, 1'b1, 25'h10,      8'hA5};
    bv[1] = '{1'b0, 25'h10,      8'hA5, 1'b1, 1'b1, 25'h200, 8'h11, 1'b0, 1'b1, 25'h200,     8'h11};
    bv[2] = '{1'b0, 25'h10,      8'hA5, 1'b0, 1'b1, 25'h200, 8'h11, 1'b1, 1'b0, 25'h200,     8'h11};
    bv[3] = '{1'b0, 25'h0,       8'h00, 1'b1, 1'b0, 25'h1FFFFFF, 8'hFF, 1'b1, 1'b0, 25'h1FFFFFF, 8'hFF};
    bv[4] = '{1'b1, 25'h1FFFFFF, 8'h00, 1'b0, 1'b0, 25'h123, 8'h77, 1'b0, 1'b1, 25'h1FFFFFF, 8'h00};

    xv[0] = '{1'b0, 1'b1, 25'h1234,    8'h5A, 2, 8'h00};
    xv[1] = '{1'b0, 1'b0, 25'h1234,    8'h00, 3, 8'h5A};
    xv[2] = '{1'b0, 1'b1, 25'h00FF,    8'hC3, 2, 8'h00};
    xv[3] = '{1'b1, 1'b0, 25'h00FF,    8'h00, 3, 8'hC3};
    xv[4] = '{1'b1, 1'b0, 25'h1FFFF80, 8'h00, 3, 8'hBC};
    xv[5] = '{1'b0, 1'b0, 25'h0055,    8'h00, 3, 8'h69};

    exp_seq = '{1, 1, 1, 1, 2, 1};

    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd3);
    check("rst_vid_ack", 32'(vid_ack), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      dl_wr = bv[i].dl_wr; dl_addr = bv[i].dl_addr; dl_data = bv[i].dl_data;
      er_busy = bv[i].er_busy; er_wr = bv[i].er_wr;
      er_addr = bv[i].er_addr; er_data = bv[i].er_data;
      vid_req = bv[i].reqs; cpu_req = bv[i].reqs;
      @(negedge clk);
      check($sformatf("byp%0d_wr", i), 32'(mem_wr), 32'(bv[i].exp_wr));
      check($sformatf("byp%0d_addr", i), 32'(mem_addr), 32'(bv[i].exp_addr));
      check($sformatf("byp%0d_din", i), 32'(mem_din), 32'(bv[i].exp_din));
      check($sformatf("byp%0d_grant", i), 32'(grant), 32'd3);
      check($sformatf("byp%0d_acks", i), 32'({vid_ack, cpu_ack}), 32'd0);
    end

    @(posedge clk); #1;
    dl_wr = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    er_busy = 1'b1; er_addr = 25'h123; er_data = 8'h77;
    rst = 1'b0;
    @(negedge clk);
    check("run_grant", 32'(grant), 32'd0);
    check("run_mem_wr", 32'(mem_wr), 32'd0);
    check("run_mem_addr", 32'(mem_addr), 32'd0);
    check("run_mem_din", 32'(mem_din), 32'd0);
    er_busy = 1'b0;

    for (int i = 0; i < 6; i++) xfer(xv[i], $sformatf("xf%0d", i));

    // Simultaneous requests: video first, CPU on the following IDLE.
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = 25'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h00FF;
    kv = -1; kc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (vid_ack && kv < 0) begin kv = k; check("tie_vid_rdata", 32'(rdata), 32'h5A); end
      if (cpu_ack && kc < 0) begin kc = k; check("tie_cpu_rdata", 32'(rdata), 32'hC3); end
      if (kv >= 0 && kc >= 0) break;
      @(posedge clk); #1;
      if (kv >= 0) vid_req = 1'b0;
      if (kc >= 0) cpu_req = 1'b0;
    end
    check("tie_vid_cycle", 32'(kv), 32'd3);
    check("tie_cpu_cycle", 32'(kc), 32'd7);
    @(posedge clk); #1;
    vid_req = 1'b0; cpu_req = 1'b0;

    // Continuous video with a waiting CPU: four video grants, then the CPU.
    @(posedge clk); #1;
    vid_req = 1'b1; vid_addr = 25'h0055;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h1FFFF80;
    n = 0; kc = -1;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      if (vid_ack && n < 6) begin seq[n] = 1; n++; end
      if (cpu_ack && n < 6) begin seq[n] = 2; n++; kc = k; end
      @(posedge clk); #1;
      if (kc >= 0) cpu_req = 1'b0;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("starve_ack_count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < n) check($sformatf("starve_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    check("starve_cpu_cycle", 32'(kc), 32'd19);

    // Video read at RD_LAT=3: ack five cycles after request, data from ACC+3.
    @(posedge clk); #1;
    vid_req3 = 1'b1; vid_addr = 25'h0055;
    c0 = cyc8;
    for (kk = 0; kk < 20; kk++) begin
      @(negedge clk);
      if (kk == 3) begin
        check("lat3_grant", 32'(grant3), 32'd1);
        check("lat3_addr", 32'(mem_addr3), 32'h55);
      end
      if (vid_ack3) break;
    end
    check("lat3_ack_cycle", 32'(kk), 32'd5);
    check("lat3_rdata", 32'(rdata3), 32'(c0 + 8'd4));
    check("lat3_side", 32'({cpu_ack3, mem_wr3, mem_din3}), 32'd0);
    @(posedge clk); #1;
    vid_req3 = 1'b0;

    // Reset during the WAIT of a CPU read aborts the transaction.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h1234;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("abort_pre_grant", 32'(grant), 32'd2);
    rst = 1'b1;
    #1;
    check("abort_grant", 32'(grant), 32'd3);
    check("abort_mem_wr", 32'(mem_wr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold%0d", i), 32'({cpu_ack, vid_ack, mem_wr}), 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_after%0d", i), 32'({grant, cpu_ack, mem_wr}), 32'd0);
    end
    check("abort_starve", 32'(u_dut.starve), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Memory-port scheduler for the Laser 500 core's single SDRAM/dpram port, clocked at F14Mx2. While the system is in reset, it passes downloader and eraser write strobes straight to the port, with the downloader taking precedence. Once out of reset, it arbitrates between two handshaked clients: the VTL video fetch channel and the CPU channel. Video has priority; a CPU starvation counter bounds CPU wait time.

## Interface
Parameters:
- ADDR_W, 25, memory address width.
- RD_LAT, 1, memory read latency in clocks (address edge to q valid); legal 1..7.
- CPU_MAX_WAIT, 4, number of consecutive video grants after which a waiting CPU request wins; legal 1..15.

Ports:
- F14Mx2  in  1  clock; all state on rising edge.
- CPU_RESET  in  1  reset CPU_RESET, asynchronous, active-high.
- dl_wr, dl_addr, dl_data  in  1/ADDR_W/8  downloader write strobe, address and data.
- er_busy, er_wr, er_addr, er_data  in  1/1/ADDR_W/8  eraser active flag, write strobe, address and data.
- vid_req  in  1  video read request (level).
- vid_addr  in  ADDR_W  video read address.
- vid_ack  out  1  video completion pulse.
- cpu_req  in  1  CPU request (level).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  CPU completion pulse.
- rdata  out  8  read data, valid in the ack cycle and held until the next read capture.
- mem_addr, mem_din, mem_wr  out  ADDR_W/8/1  memory port address, write data and write enable.
- mem_dout  in  8  memory port read data.
- grant  out  2  current owner: 0 = none, 1 = video, 2 = CPU, 3 = loader bypass.

## Operation
- **Bypass (CPU_RESET=1):** the FSM is held in IDLE and all registers are cleared. Port driving is combinational:
  - if dl_wr: mem_* carry dl_addr and dl_data, mem_wr=1;
  - else if er_busy&er_wr: mem_* carry er_addr and er_data, mem_wr=1;
  - else: mem_wr=0, with mem_addr and mem_din showing the eraser values.
  - grant=3; vid_ack=cpu_ack=0; vid_req and cpu_req are ignored.
- **Normal mode (CPU_RESET=0):** loader inputs are ignored. The port is driven from registered owner, address, we and data.
- FSM states: IDLE, ACC, WAIT, ACK.
  - **IDLE:** arbitrate on the sampled requests, in this order:
    - cpu_req && starve==CPU_MAX_WAIT → CPU;
    - else vid_req → video;
    - else cpu_req → CPU;
    - else stay in IDLE.
    - On a grant, latch owner, address, we (video always read) and wdata, then go to ACC.
  - **ACC:** exactly one cycle driving mem_addr; mem_wr=we.
    - Write → ACK.
    - Read → WAIT, with the latency counter loaded to RD_LAT.
  - **WAIT:** the counter decrements each cycle. When it is 1, capture mem_dout into rdata at the clock edge and go to ACK.
  - **ACK:** pulse the owner's ack for one cycle, then return to IDLE. grant returns to 0 in IDLE.
- **Starvation counter** (starve, 4 bits, saturating at CPU_MAX_WAIT):
  - increments at each IDLE grant to video while cpu_req=1;
  - clears on a CPU grant or whenever cpu_req=0 in IDLE.
- mem_wr is asserted only in ACC. Outside ACC, mem_addr and mem_din hold the last latched values, so there are no spurious writes.
- Client rule: hold req, addr, we and wdata stable from req rise until ack is seen; drop req on the clock following ack. A req still high in the cycle after ACK is treated as a new request.
- Simultaneous vid_req and cpu_req with starve<CPU_MAX_WAIT → video wins; the CPU is served at the next IDLE unless video is re-requested.
- CPU_RESET rising mid-transaction aborts immediately: no ack, mem_wr drops in the same cycle (bypass takes over), and the client request is lost.

## Timing
- Reset values: state=IDLE, grant=0 (3 while CPU_RESET is held), vid_ack=cpu_ack=0, rdata=0, registered mem_addr=0, mem_din=0, mem_wr=0, starve=0.
- Read, req first high in IDLE cycle N: ACC at N+1, WAIT at N+2..N+1+RD_LAT, ack at N+2+RD_LAT. This gives ack at N+3 for RD_LAT=1.
- Write: ACC at N+1, ack at N+2.
- Back-to-back throughput: one read per 3+RD_LAT cycles, one write per 3 cycles (including the IDLE cycle).
- Worst-case CPU wait with continuous video: CPU_MAX_WAIT video transactions plus one.
- Bypass path: zero latency from dl_wr/er_wr to mem_wr.

## Test plan
- Hold CPU_RESET, pulse dl_wr at addr 0x00010 with data 0xA5 while er_wr is active → mem_wr=1, mem_addr=0x00010, mem_din=0xA5, grant=3, no acks.
- Release reset, CPU write 0x1234←0x5A with the model memory at RD_LAT=1 → mem_wr high exactly one cycle with the address/data on the port, cpu_ack at N+2; a following CPU read of 0x1234 → cpu_ack at N+3 with rdata=0x5A.
- vid_req and cpu_req rise together → video is served first (vid_ack), then the CPU (cpu_ack); neither ack ever overlaps the other.
- Keep vid_req continuously re-asserted with cpu_req held and CPU_MAX_WAIT=4 → exactly 4 vid_acks, then cpu_ack, then video resumes.
- RD_LAT=3, video read → vid_ack at N+5; rdata equals mem_dout sampled 3 cycles after ACC.
- Assert CPU_RESET during WAIT of a CPU read → no cpu_ack ever, mem_wr=0 (absent loader strobes), FSM in IDLE after release, starve=0.
